vram_access_arbiter: RTL and testbench

//  Shares one single-port synchronous video RAM between the VGA scan-out reader and the CPU

---
 rtl/vram_access_arbiter.sv | 83 ++++++++
 tb/tb_vram_access_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_access_arbiter.sv
// Single-port VRAM arbiter: VGA scan-out has priority, the CPU is guaranteed a slot after
// MAX_WAIT lost cycles. Read data returns one cycle after the grant, flagged to its owner.
module vram_access_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4,
    parameter int WCW      = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          vga_req_i,
    input  logic [AW-1:0] vga_addr_i,
    output logic          vga_gnt_o,
    output logic [DW-1:0] vga_rdata_o,
    output logic          vga_rvalid_o,

    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_gnt_o,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_rvalid_o,

    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    logic [WCW-1:0] wait_cnt_q;
    logic [WCW-1:0] wait_cnt_d;
    logic           vga_rvalid_q;
    logic           cpu_rvalid_q;
    logic           force_cpu;
    logic           cpu_gnt;
    logic           vga_gnt;

    // Grants are gated by reset so nothing reaches the RAM while the block is held in reset.
    always_comb begin
        force_cpu = cpu_req_i && (wait_cnt_q == WAIT_MAX);
        cpu_gnt   = rst_ni && cpu_req_i && (!vga_req_i || force_cpu);
        vga_gnt   = rst_ni && vga_req_i && !cpu_gnt;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!cpu_req_i || cpu_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_cnt_q   <= '0;
            vga_rvalid_q <= 1'b0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            vga_rvalid_q <= vga_gnt;
            cpu_rvalid_q <= cpu_gnt && !cpu_we_i;
        end
    end

    assign vga_gnt_o    = vga_gnt;
    assign cpu_gnt_o    = cpu_gnt;
    assign vga_rvalid_o = vga_rvalid_q;
    assign cpu_rvalid_o = cpu_rvalid_q;
    assign vga_rdata_o  = mem_rdata_i;
    assign cpu_rdata_o  = mem_rdata_i;

    assign mem_en_o    = vga_gnt | cpu_gnt;
    assign mem_we_o    = cpu_gnt & cpu_we_i;
    assign mem_addr_o  = cpu_gnt ? cpu_addr_i : vga_addr_i;
    assign mem_wdata_o = cpu_wdata_i;

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Directed and constrained-random checks of the VRAM arbiter against a small VRAM model and
// an independent arbitration/scoreboard model.
module tb_vram_access_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic          vga_gnt;
    logic [DW-1:0] vga_rdata;
    logic          vga_rvalid;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    vram_access_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4), .WCW(3)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .vga_req_i    (vga_req),
        .vga_addr_i   (vga_addr),
        .vga_gnt_o    (vga_gnt),
        .vga_rdata_o  (vga_rdata),
        .vga_rvalid_o (vga_rvalid),
        .cpu_req_i    (cpu_req),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_gnt_o    (cpu_gnt),
        .cpu_rdata_o  (cpu_rdata),
        .cpu_rvalid_o (cpu_rvalid),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return (32'h0101_0101 * i) ^ 32'hA5A5_0000;
    endfunction

    // VRAM model: 256 words, one-cycle read latency, loaded on the first clock edge.
    logic [DW-1:0] vram [0:255];
    bit            vram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!vram_loaded) begin
            for (int i = 0; i < 256; i++) vram[i] <= init_word(i);
            vram_loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) vram[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= vram[mem_addr[7:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard state for the random phase
    logic [DW-1:0] shadow [0:255];
    int            m_wait;
    int            cpu_lost;
    logic          exp_vgnt, exp_cgnt, exp_force;
    logic          exp_vrv, exp_crv;
    logic [DW-1:0] exp_vdata, exp_cdata;
    logic          v_pend, c_pend;

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        rst_n = 1'b0; vga_req = 1'b1; vga_addr = 16'h0020;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = '0;

        // 1: reset blocks everything
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("rst_vga_gnt", vga_gnt, 0);
            check_eq("rst_cpu_gnt", cpu_gnt, 0);
            check_eq("rst_mem_en",  mem_en,  0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; vga_req = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check_eq("rst_vga_rvalid", vga_rvalid, 0);
        check_eq("rst_cpu_rvalid", cpu_rvalid, 0);
        $display("[TB] t1 reset hold done");

        // 2: CPU-only write then read back
        next_cycle;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("wr_cpu_gnt",  cpu_gnt,  1);
        check_eq("wr_mem_we",   mem_we,   1);
        check_eq("wr_mem_addr", mem_addr, 16'h0010);
        check_eq("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        $display("[TB] t2 cpu write 0010 <= deadbeef");
        next_cycle;
        cpu_we = 1'b0;
        @(negedge clk);
        check_eq("rd_cpu_gnt",      cpu_gnt,    1);
        check_eq("rd_mem_we",       mem_we,     0);
        check_eq("wr_no_cpu_rvalid", cpu_rvalid, 0);
        next_cycle;
        cpu_req = 1'b0;
        @(negedge clk);
        check_eq("rd_cpu_rvalid", cpu_rvalid, 1);
        check_eq("rd_cpu_rdata",  cpu_rdata,  32'hDEAD_BEEF);
        check_eq("rd_vga_rvalid", vga_rvalid, 0);
        $display("[TB] t2 cpu read 0010 => %h", cpu_rdata);

        // 3: both held high -> V,V,V,V,C repeating
        next_cycle;
        vga_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("pat_vga_gnt", vga_gnt, (k % 5) != 4);
            check_eq("pat_cpu_gnt", cpu_gnt, (k % 5) == 4);
            $display("[TB] t3 cycle %0d vga_gnt=%0b cpu_gnt=%0b", k, vga_gnt, cpu_gnt);
            next_cycle;
        end

        // 4: single contention cycle, then CPU drops its request
        vga_req = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        next_cycle;
        vga_req = 1'b1; cpu_req = 1'b1;
        @(negedge clk);
        check_eq("tie_vga_gnt", vga_gnt, 1);
        check_eq("tie_cpu_gnt", cpu_gnt, 0);
        next_cycle;
        vga_req = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check_eq("tie_wait_cnt1", dut.wait_cnt_q, 1);
        next_cycle;
        @(negedge clk);
        check_eq("drop_wait_cnt0", dut.wait_cnt_q, 0);
        $display("[TB] t4 tie and drop done");

        // 5: reset right after a CPU read grant suppresses its rvalid
        next_cycle;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        @(negedge clk);
        check_eq("rr_cpu_gnt", cpu_gnt, 1);
        rst_n = 1'b0;
        next_cycle;
        @(negedge clk);
        check_eq("rr_cpu_rvalid", cpu_rvalid, 0);
        check_eq("rr_blocked_gnt", cpu_gnt, 0);
        check_eq("rr_mem_en", mem_en, 0);
        next_cycle;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rr_release_gnt", cpu_gnt, 1);
        check_eq("rr_release_rvalid", cpu_rvalid, 0);
        next_cycle;
        cpu_req = 1'b0;
        @(negedge clk);
        check_eq("rr_after_rvalid", cpu_rvalid, 1);
        check_eq("rr_after_rdata",  cpu_rdata,  32'hDEAD_BEEF);
        $display("[TB] t5 reset-after-grant done");

        // 6: random traffic against the scoreboard
        m_wait = 0; cpu_lost = 0; exp_vrv = 1'b0; exp_crv = 1'b0;
        exp_vdata = '0; exp_cdata = '0; v_pend = 1'b0; c_pend = 1'b0;
        for (int k = 0; k < 150; k++) begin
            next_cycle;
            if (!(v_pend && $urandom_range(7) != 0)) begin
                vga_req  = $urandom_range(9) < 7;
                vga_addr = 16'h0040 + 16'($urandom_range(15));
            end
            if (!(c_pend && $urandom_range(7) != 0)) begin
                cpu_req   = $urandom_range(9) < 6;
                cpu_we    = $urandom_range(2) == 0;
                cpu_addr  = 16'h0040 + 16'($urandom_range(15));
                cpu_wdata = $urandom;
            end
            @(negedge clk);
            exp_force = cpu_req && (m_wait == 4);
            exp_cgnt  = cpu_req && (!vga_req || exp_force);
            exp_vgnt  = vga_req && !exp_cgnt;
            check_eq("rnd_vga_gnt", vga_gnt, exp_vgnt);
            check_eq("rnd_cpu_gnt", cpu_gnt, exp_cgnt);
            check_eq("rnd_mem_en",  mem_en,  exp_vgnt || exp_cgnt);
            check_eq("rnd_mem_we",  mem_we,  exp_cgnt && cpu_we);
            if (exp_vgnt || exp_cgnt)
                check_eq("rnd_mem_addr", mem_addr, exp_cgnt ? cpu_addr : vga_addr);
            check_eq("rnd_vga_rvalid", vga_rvalid, exp_vrv);
            check_eq("rnd_cpu_rvalid", cpu_rvalid, exp_crv);
            if (exp_vrv) check_eq("rnd_vga_rdata", vga_rdata, exp_vdata);
            if (exp_crv) check_eq("rnd_cpu_rdata", cpu_rdata, exp_cdata);
            cpu_lost = (cpu_req && !cpu_gnt) ? cpu_lost + 1 : 0;
            check_eq("rnd_wait_bound", cpu_lost <= 4, 1);
            if (exp_vgnt || exp_cgnt)
                $display("[TB] t6 cyc %0d %s addr=%h we=%0b", k, exp_cgnt ? "CPU" : "VGA",
                         exp_cgnt ? cpu_addr : vga_addr, exp_cgnt && cpu_we);

            exp_vrv   = exp_vgnt;
            exp_vdata = shadow[vga_addr[7:0]];
            exp_crv   = exp_cgnt && !cpu_we;
            exp_cdata = shadow[cpu_addr[7:0]];
            if (exp_cgnt && cpu_we) shadow[cpu_addr[7:0]] = cpu_wdata;
            m_wait = (cpu_req && !exp_cgnt) ? ((m_wait < 4) ? m_wait + 1 : 4) : 0;
            v_pend = vga_req && !exp_vgnt;
            c_pend = cpu_req && !exp_cgnt;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
